// File: rtl/rx_serial_pkg.sv
// rtl/rx_serial_pkg.sv - shared state codes, DIV helper and command byte for rx_serial_8n1
package rx_serial_pkg;

  // State codes, also shown on db_estado
  localparam logic [3:0] COD_INICIAL   = 4'h0;
  localparam logic [3:0] COD_ESPERA    = 4'h1;
  localparam logic [3:0] COD_INICIO    = 4'h2;
  localparam logic [3:0] COD_DADOS     = 4'h3;
  localparam logic [3:0] COD_PARADA    = 4'h4;
  localparam logic [3:0] COD_ARMAZENA  = 4'h5;
  localparam logic [3:0] COD_ERRO      = 4'h6;
  localparam logic [3:0] COD_AGUARDA   = 4'h7;
  localparam logic [3:0] COD_INVALIDO  = 4'hF;

  typedef enum logic [3:0] {
    S_INICIAL  = COD_INICIAL,
    S_ESPERA   = COD_ESPERA,
    S_INICIO   = COD_INICIO,
    S_DADOS    = COD_DADOS,
    S_PARADA   = COD_PARADA,
    S_ARMAZENA = COD_ARMAZENA,
    S_ERRO     = COD_ERRO,
    S_AGUARDA  = COD_AGUARDA
  } state_t;

  // Position-change command byte ('#'), shared with the control unit
  localparam logic [7:0] CMD_CHAR_DEF = 8'h23;

  // Clock cycles per bit; integer division, caller must keep the result >= 4
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_serial_8n1_contador_baud.sv
// rtl/rx_serial_8n1_contador_baud.sv - baud counter, counts 0..limite-1 and flags the last count
module contador_baud #(
  parameter int M = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       zera,
  input  logic                       conta,
  input  logic [$clog2(M+1)-1:0]     limite,
  output logic                       fim
);

  localparam int W = $clog2(M + 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign fim = conta && (cnt == (limite - ONE));

  // Count while enabled, wrap after the last count, clear on request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= fim ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/rx_serial_8n1.sv
// rtl/rx_serial_8n1.sv - 8N1 LSB-first UART receiver with command-byte detection
module rx_serial_8n1
  import rx_serial_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 115_200,
  parameter logic [7:0] CMD_CHAR = CMD_CHAR_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dados,
  output logic       fim_recepcao,
  output logic       comando,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] LIM_FULL = CW'(DIV);
  localparam logic [CW-1:0] LIM_HALF = CW'(DIV / 2);

  logic          sync1;
  logic          rx_s;
  state_t        state;
  state_t        state_next;
  logic          zera;
  logic          conta;
  logic          tick;
  logic [CW-1:0] limite;
  logic [2:0]    idx;
  logic [7:0]    shift;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX;
      rx_s  <= sync1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_INICIAL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and debug state code
  always_comb begin
    state_next = state;
    db_estado  = COD_INVALIDO;
    case (state)
      S_INICIAL: begin
        db_estado  = COD_INICIAL;
        state_next = S_ESPERA;
      end
      S_ESPERA: begin
        db_estado = COD_ESPERA;
        if (!rx_s) state_next = S_INICIO;
      end
      S_INICIO: begin
        db_estado = COD_INICIO;
        // A line that is high again at mid-start was only a glitch
        if (tick) state_next = rx_s ? S_ESPERA : S_DADOS;
      end
      S_DADOS: begin
        db_estado = COD_DADOS;
        if (tick && (idx == 3'd7)) state_next = S_PARADA;
      end
      S_PARADA: begin
        db_estado = COD_PARADA;
        if (tick) state_next = rx_s ? S_ARMAZENA : S_ERRO;
      end
      S_ARMAZENA: begin
        db_estado  = COD_ARMAZENA;
        state_next = S_ESPERA;
      end
      S_ERRO: begin
        db_estado  = COD_ERRO;
        state_next = S_AGUARDA;
      end
      S_AGUARDA: begin
        db_estado = COD_AGUARDA;
        // Break or stuck-low line: do not hunt for a start bit until idle
        if (rx_s) state_next = S_ESPERA;
      end
      default: begin
        db_estado  = COD_INVALIDO;
        state_next = S_INICIAL;
      end
    endcase
  end

  // Baud counter control: restart on every state change, half bit in inicio
  always_comb begin
    zera   = (state_next != state);
    conta  = (state == S_INICIO) || (state == S_DADOS) || (state == S_PARADA);
    limite = (state == S_INICIO) ? LIM_HALF : LIM_FULL;
  end

  contador_baud #(.M(DIV)) u_contador_baud (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera),
    .conta  (conta),
    .limite (limite),
    .fim    (tick)
  );

  // Bit index and shift register; bit 0 arrives first
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx   <= 3'd0;
      shift <= 8'h00;
    end else if (state != S_DADOS) begin
      idx <= 3'd0;
    end else if (tick) begin
      shift[idx] <= rx_s;
      idx        <= idx + 3'd1;
    end
  end

  // Outputs registered from the next state so they line up with armazena/erro
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados        <= 8'h00;
      comando      <= 1'b0;
      fim_recepcao <= 1'b0;
      erro_quadro  <= 1'b0;
    end else begin
      fim_recepcao <= (state_next == S_ARMAZENA);
      erro_quadro  <= (state_next == S_ERRO);
      if (state_next == S_ARMAZENA) begin
        dados   <= shift;
        comando <= (shift == CMD_CHAR);
      end
    end
  end

endmodule

// File: tb/tb_rx_serial_8n1.sv
// tb/tb_rx_serial_8n1.sv - directed self-checking bench for rx_serial_8n1
module tb_rx_serial_8n1;
  import rx_serial_pkg::*;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RX    = 1'b1;
  logic [7:0] dados;
  logic       fim_recepcao;
  logic       comando;
  logic       erro_quadro;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;

  rx_serial_8n1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .CMD_CHAR (CMD_CHAR_DEF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .RX           (RX),
    .dados        (dados),
    .fim_recepcao (fim_recepcao),
    .comando      (comando),
    .erro_quadro  (erro_quadro),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Free-running cycle count
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse observer, sampled on the falling edge
  int         fim_cnt = 0;
  int         erro_cnt = 0;
  int         both_cnt = 0;
  int         inicio_cnt = 0;
  int         fim_cyc = 0;
  int         fim_cyc_prev = 0;
  logic [7:0] dados_at_fim = 8'h00;
  logic       comando_at_fim = 1'b0;
  always @(negedge clock) begin
    if (fim_recepcao) begin
      fim_cnt        <= fim_cnt + 1;
      fim_cyc_prev   <= fim_cyc;
      fim_cyc        <= cyc;
      dados_at_fim   <= dados;
      comando_at_fim <= comando;
    end
    if (erro_quadro) erro_cnt <= erro_cnt + 1;
    if (fim_recepcao && erro_quadro) both_cnt <= both_cnt + 1;
    if (db_estado == COD_INICIO) inicio_cnt <= inicio_cnt + 1;
  end

  task automatic send_bit(input logic b);
    RX = b;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    RX    = 1'b1;
    repeat (3) @(negedge clock);
    tests++; if (dados !== 8'h00) begin fails++; $display("FAIL reset_dados: got %h expected 00", dados); end
    tests++; if (fim_recepcao !== 1'b0) begin fails++; $display("FAIL reset_fim: got %b expected 0", fim_recepcao); end
    tests++; if (comando !== 1'b0) begin fails++; $display("FAIL reset_comando: got %b expected 0", comando); end
    tests++; if (erro_quadro !== 1'b0) begin fails++; $display("FAIL reset_erro: got %b expected 0", erro_quadro); end
    tests++; if (db_estado !== 4'h0) begin fails++; $display("FAIL reset_estado: got %h expected 0", db_estado); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests++; if (db_estado !== 4'h1) begin fails++; $display("FAIL reset_to_espera: got %h expected 1", db_estado); end
  endtask

  task automatic test_single_byte;
    int fb, eb, t_start, lat;
    fb = fim_cnt; eb = erro_cnt; t_start = cyc;
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clock);
    lat = fim_cyc - t_start;
    tests++; if (fim_cnt - fb !== 1) begin fails++; $display("FAIL byte55_pulses: got %0d expected 1", fim_cnt - fb); end
    // 2 synchronizer cycles + 154 cycles from t0, +/-1
    tests++; if (lat < 155 || lat > 157) begin fails++; $display("FAIL byte55_latency: got %0d expected 155..157", lat); end
    tests++; if (dados !== 8'h55) begin fails++; $display("FAIL byte55_dados: got %h expected 55", dados); end
    tests++; if (comando !== 1'b0) begin fails++; $display("FAIL byte55_comando: got %b expected 0", comando); end
    tests++; if (erro_cnt - eb !== 0) begin fails++; $display("FAIL byte55_erro: got %0d expected 0", erro_cnt - eb); end
  endtask

  task automatic test_command;
    int fb;
    fb = fim_cnt;
    send_frame(8'h23, 1'b1);
    repeat (4) @(negedge clock);
    tests++; if (fim_cnt - fb !== 1) begin fails++; $display("FAIL cmd_pulses: got %0d expected 1", fim_cnt - fb); end
    tests++; if (dados_at_fim !== 8'h23) begin fails++; $display("FAIL cmd_dados: got %h expected 23", dados_at_fim); end
    tests++; if (comando_at_fim !== 1'b1) begin fails++; $display("FAIL cmd_comando_at_fim: got %b expected 1", comando_at_fim); end
    tests++; if (comando !== 1'b1) begin fails++; $display("FAIL cmd_comando_held: got %b expected 1", comando); end
    send_frame(8'h41, 1'b1);
    repeat (4) @(negedge clock);
    tests++; if (dados_at_fim !== 8'h41) begin fails++; $display("FAIL cmd41_dados: got %h expected 41", dados_at_fim); end
    tests++; if (comando_at_fim !== 1'b0) begin fails++; $display("FAIL cmd41_comando: got %b expected 0", comando_at_fim); end
  endtask

  task automatic test_frame_error;
    int fb, eb;
    logic [7:0] d;
    fb = fim_cnt; eb = erro_cnt; d = 8'hA7;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    RX = 1'b0;
    repeat (DIV + 40) @(negedge clock);
    tests++; if (erro_cnt - eb !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d expected 1", erro_cnt - eb); end
    tests++; if (fim_cnt - fb !== 0) begin fails++; $display("FAIL ferr_fim: got %0d expected 0", fim_cnt - fb); end
    tests++; if (dados !== 8'h41) begin fails++; $display("FAIL ferr_dados: got %h expected 41", dados); end
    tests++; if (db_estado !== 4'h7) begin fails++; $display("FAIL ferr_aguarda: got %h expected 7", db_estado); end
    RX = 1'b1;
    repeat (4) @(negedge clock);
    tests++; if (db_estado !== 4'h1) begin fails++; $display("FAIL ferr_recover: got %h expected 1", db_estado); end
  endtask

  task automatic test_glitch;
    int fb, eb, ib;
    fb = fim_cnt; eb = erro_cnt; ib = inicio_cnt;
    RX = 1'b0;
    repeat (5) @(negedge clock);
    RX = 1'b1;
    repeat (30) @(negedge clock);
    tests++; if (inicio_cnt - ib < 1) begin fails++; $display("FAIL glitch_inicio_seen: got %0d expected >=1", inicio_cnt - ib); end
    tests++; if (db_estado !== 4'h1) begin fails++; $display("FAIL glitch_estado: got %h expected 1", db_estado); end
    tests++; if ((fim_cnt - fb) + (erro_cnt - eb) !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d expected 0", (fim_cnt - fb) + (erro_cnt - eb)); end
    tests++; if (dados !== 8'h41) begin fails++; $display("FAIL glitch_dados: got %h expected 41", dados); end
  endtask

  task automatic test_back_to_back;
    int fb;
    fb = fim_cnt;
    send_frame(8'h01, 1'b1);
    tests++; if (dados !== 8'h01) begin fails++; $display("FAIL b2b_first: got %h expected 01", dados); end
    send_frame(8'hFE, 1'b1);
    repeat (4) @(negedge clock);
    tests++; if (dados !== 8'hFE) begin fails++; $display("FAIL b2b_second: got %h expected FE", dados); end
    tests++; if (fim_cnt - fb !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d expected 2", fim_cnt - fb); end
    tests++; if (fim_cyc - fim_cyc_prev !== 160) begin fails++; $display("FAIL b2b_spacing: got %0d expected 160", fim_cyc - fim_cyc_prev); end
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL pulse_exclusive: got %0d expected 0", both_cnt); end
  endtask

  task automatic test_reset_midframe;
    int fb, eb, bad;
    logic [7:0] d;
    d = 8'h96; bad = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    RX = d[4];
    repeat (DIV / 2) @(negedge clock);
    reset = 1'b0;
    #1;
    tests++; if ({dados, comando, fim_recepcao, erro_quadro, db_estado} !== 15'h0) begin fails++; $display("FAIL rst_mid_immediate: got dados=%h cmd=%b fim=%b err=%b est=%h expected all 0", dados, comando, fim_recepcao, erro_quadro, db_estado); end
    repeat (3) begin
      @(negedge clock);
      if ({dados, comando, fim_recepcao, erro_quadro, db_estado} !== 15'h0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rst_mid_hold: got %0d nonzero samples expected 0", bad); end
    fb = fim_cnt; eb = erro_cnt;
    reset = 1'b1;
    RX = 1'b1;
    repeat (40) @(negedge clock);
    tests++; if (dados !== 8'h00 || comando !== 1'b0) begin fails++; $display("FAIL rst_mid_after: got dados=%h cmd=%b expected 00/0", dados, comando); end
    tests++; if ((fim_cnt - fb) + (erro_cnt - eb) !== 0) begin fails++; $display("FAIL rst_mid_pulses: got %0d expected 0", (fim_cnt - fb) + (erro_cnt - eb)); end
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    tests++; if (dados !== 8'h3C) begin fails++; $display("FAIL rst_mid_next_dados: got %h expected 3C", dados); end
    tests++; if (fim_cnt - fb !== 1) begin fails++; $display("FAIL rst_mid_next_pulses: got %0d expected 1", fim_cnt - fb); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_byte();
    test_command();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_serial_8n1.md
Name: rx_serial_8n1

Overview:
UART receiver, 8N1 format, LSB first. Sits directly upstream of the door/position control unit. It turns the serial line RX into a parallel byte plus a one-cycle end-of-reception pulse, and flags whether the byte is the position-change command. Its fim_recepcao/comando outputs drive the control unit's fimRecepcao/comando inputs; dados feeds the data register enabled by that unit.

Parameters:
CLK_FREQ  50_000_000  system clock frequency in Hz
BAUD  115_200  line rate in bit/s; DIV = CLK_FREQ/BAUD (integer division), must be >= 4
CMD_CHAR  8'h23  byte value ('#') that raises comando

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
RX  input  1  asynchronous serial line, idle high
dados  output  8  last correctly framed byte
fim_recepcao  output  1  one-cycle pulse: valid frame received
comando  output  1  1 when dados == CMD_CHAR; valid from the fim_recepcao cycle, held
erro_quadro  output  1  one-cycle pulse: stop bit sampled low
db_estado  output  4  current FSM state code, for debug displays

Behaviour:
- Reset (reset=0, asynchronous): state=inicial, dados=8'h00, fim_recepcao=0, comando=0, erro_quadro=0, synchronizer flops=1, counters=0.
- RX passes through a 2-flop synchronizer. rx_s is the second flop's output. All sampling uses rx_s.
- Baud counter: counts 0..limit-1 and asserts tick on the last count. It is cleared on every state entry.
- FSM states and db_estado codes:
  - inicial (0): go to espera the next cycle.
  - espera (1): wait for rx_s==0, then go to inicio.
  - inicio (2): wait DIV/2 cycles, then sample. rx_s==1 is a false start: return to espera with no pulses. rx_s==0 goes to dados with bit index=0.
  - dados (3): wait DIV cycles, then sample rx_s into shift[index]. Bit 0 is first. After index 7 go to parada.
  - parada (4): wait DIV cycles, then sample. rx_s==1 goes to armazena. rx_s==0 goes to erro.
  - armazena (5): for one cycle load dados<=shift, comando<=(shift==CMD_CHAR), fim_recepcao=1. Then go to espera.
  - erro (6): for one cycle erro_quadro=1. dados and comando are unchanged. Then go to aguarda_idle.
  - aguarda_idle (7): wait for rx_s==1 (break/stuck-low line), then go to espera.
  - Any other code: go to inicial and show db_estado=4'hF.
- fim_recepcao and erro_quadro are registered, asserted for exactly 1 cycle, and mutually exclusive.
- Latency: the first rx_s==0 cycle in espera is t0. The armazena cycle (fim_recepcao=1) is t0 + 1 + DIV/2 + 9*DIV + 1, within ±1 cycle of the synchronizer.
- dados and comando hold between frames. They change only in armazena.
- A new start bit is accepted in the cycle after armazena. Back-to-back frames with no idle time must be received without loss.
- RX glitches shorter than DIV/2 during espera are rejected by the mid-start check.
- A reset assertion mid-frame aborts the frame immediately with no pulses. After release, reception restarts from inicial.

Decomposition:
- Shared package rx_serial_pkg holds:
  - the state encodings/db_estado codes (4-bit localparams);
  - DIV derivation helper;
  - CMD_CHAR default, so the control unit and bench use the same value.
- Sub-module contador_baud (parameter M): inputs clock, reset, zera, conta, limite; output fim. Used for both the half-bit and full-bit waits.
- Bit index is a 3-bit counter in the top module.

Test Plan (bench with CLK_FREQ=16, BAUD=1, so DIV=16):
- Send 8'h55 framed correctly -> single fim_recepcao pulse at t0+154 (±1), dados=8'h55, comando=0, erro_quadro never 1.
- Send 8'h23 -> dados=8'h23, comando=1 in the same cycle as fim_recepcao. Then send 8'h41 -> comando returns to 0 with that pulse.
- Send 8'hA7 with stop bit=0, then hold RX low 40 cycles -> erro_quadro pulses once, dados keeps its previous value, db_estado=7 until RX returns high, then 1.
- Drive a 5-cycle low glitch on idle RX -> db_estado returns 2→1, no pulses, dados unchanged.
- Send two frames back-to-back (8'h01, 8'hFE) with zero idle -> two fim_recepcao pulses 160 cycles apart, dados=8'h01 then 8'hFE.
- Assert reset=0 during bit 4 of a frame for 3 cycles -> all outputs read 0 immediately and stay 0. The next full frame 8'h3C is received correctly.
